stream_maxpool2x2: RTL and testbench
====================================

// Module: stream_maxpool2x2
// PURPOSE
//  Streaming 2x2/stride-2 max-pool stage for the CNN datapath. Consumes one
//  post-ReLU pixel per valid cycle in raster order and emits one pooled
//  pixel per 2x2 window. Replaces fixed-depth shift-register pooling:
//  feature-map width/height are runtime-programmed, input is valid-gated,
//  and a bypass mode passes pixels straight through.
// PARAMETERS
//  DATA_W   21  pixel width, unsigned (post-ReLU)
//  MAX_COLS 64  largest supported row width; line buffer = MAX_COLS/2 words
//  DIM_W    7   width of i_cols/i_rows; must hold MAX_COLS
// PORTS
//  clk      in  1       clock, rising edge
//  rst_n    in  1       asynchronous, active-low reset
//  i_start  in  1       1-cycle pulse: latch config, begin frame
//  i_cols   in  DIM_W   frame width; even, 2..MAX_COLS
//  i_rows   in  DIM_W   frame height; even, >=2
//  i_bypass in  1       1 = pass-through, no pooling
//  i_valid  in  1       i_data valid this cycle
//  i_data   in  DATA_W  input pixel, raster order
//  o_valid  out 1       o_data valid this cycle
//  o_data   out DATA_W  pooled (or bypassed) pixel
//  o_busy   out 1       high in RUN
//  o_done   out 1       1-cycle pulse after last frame pixel output
//  o_err    out 1       1-cycle pulse: i_start with illegal config
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, line buffer contents don't-care.
//  FSM IDLE/RUN/DONE:
//   IDLE: i_valid ignored. i_start with legal cfg -> latch cols/rows/bypass,
//    clear col/row counters, go RUN next cycle. Illegal cfg (odd, zero,
//    cols>MAX_COLS, rows<2) -> o_err=1 next cycle, stay IDLE.
//   RUN: o_busy=1. i_start ignored; cfg inputs ignored (latched copy used).
//    Each i_valid advances col; col wraps cols-1->0 and increments row.
//    Accepting pixel (rows-1, cols-1) -> DONE next cycle.
//   DONE: o_done=1 for exactly 1 cycle, -> IDLE. o_valid of the last output
//    coincides with the DONE cycle.
//  Pooling (bypass=0), c=col, r=row, h=c>>1:
//   even c: hold pixel in pair register.
//   odd c, even r: lbuf[h] <= max(pair, i_data).
//   odd c, odd r:  o_data <= max(lbuf[h], pair, i_data), o_valid=1.
//   Latency: o_valid exactly 1 cycle after the accepting edge of the window's
//    bottom-right pixel. Output count = (cols/2)*(rows/2) per frame.
//   Compare unsigned; ties return equal value; no width growth.
//  Bypass=1: o_data <= i_data, o_valid <= i_valid (1-cycle latency); counters
//   still run so o_done fires after cols*rows inputs.
//  i_valid gaps: any number of idle cycles between pixels; state holds,
//   output unaffected. o_valid=0 in cycles with no completed window.
//  o_data holds last value when o_valid=0.
//  rst_n low mid-frame: immediate abort to IDLE, outputs 0, no o_done.
// TESTING
//  4x4 frame, pixels 0..15 raster, i_valid continuous -> o_valid 4 times:
//   5,7,13,15; o_done 1 cycle after the 15 output edge region (DONE cycle).
//  Same frame, i_valid toggling 1/0 -> identical outputs 5,7,13,15; no extra
//   o_valid.
//  cols=MAX_COLS=64, rows=2, pixel=(c==37)?1000:c -> 32 outputs, output h=18
//   is 1000, others 2h+1; verifies full line buffer depth and wrap.
//  i_start with cols=5 -> o_err pulse, o_busy stays 0; then cols=0, rows=3
//   -> o_err each time.
//  bypass=1, 2x2, pixels 9,3,8,1 -> o_data 9,3,8,1, each 1 cycle after input;
//   o_done after 4th.
//  rst_n low after 6 pixels of 4x4 frame -> all outputs 0, IDLE; new 2x2
//   frame 1,2,3,4 -> single output 4, no stale line-buffer effect.

Source files
------------

// File: rtl/stream_maxpool2x2.sv
// Streaming 2x2/stride-2 max-pool over a runtime-sized raster frame, with bypass.
// A half-row line buffer holds each even row's horizontal pair maxima for the odd row below.
module stream_maxpool2x2 #(
  parameter int DATA_W   = 21,
  parameter int MAX_COLS = 64,
  parameter int DIM_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_cols,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic              i_bypass,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int HALF = MAX_COLS / 2;
  localparam int AW   = $clog2(HALF);
  localparam logic [DIM_W-1:0] MAX_C = DIM_W'(MAX_COLS);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [DIM_W-1:0]  cols_q, rows_q, col, row;
  logic              bypass_q;
  logic [DATA_W-1:0] pair_q;
  logic [DATA_W-1:0] lbuf [HALF];
  logic [DATA_W-1:0] m2, lb_rd, m3;
  logic [AW-1:0]     h;
  logic              cfg_ok, accept, col_end, last_px;

  assign cfg_ok  = (i_cols != '0) && !i_cols[0] && (i_cols <= MAX_C) &&
                   (i_rows >= TWO) && !i_rows[0];
  assign accept  = (state == RUN) && i_valid;
  assign col_end = (col == cols_q - ONE);
  assign last_px = accept && col_end && (row == rows_q - ONE);
  assign h       = col[AW:1];
  assign m2      = (pair_q > i_data) ? pair_q : i_data;
  assign lb_rd   = lbuf[h];
  assign m3      = (lb_rd > m2) ? lb_rd : m2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start && cfg_ok) state_nx = RUN;
      RUN:     if (last_px) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == RUN);
    o_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q   <= '0;
      rows_q   <= '0;
      bypass_q <= 1'b0;
      col      <= '0;
      row      <= '0;
      pair_q   <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= (state == IDLE) && i_start && !cfg_ok;
      if ((state == IDLE) && i_start && cfg_ok) begin
        cols_q   <= i_cols;
        rows_q   <= i_rows;
        bypass_q <= i_bypass;
        col      <= '0;
        row      <= '0;
      end
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
        if (bypass_q) begin
          o_valid <= 1'b1;
          o_data  <= i_data;
        end else if (!col[0]) begin
          pair_q <= i_data;
        end else if (row[0]) begin
          // bottom-right pixel closes the window
          o_valid <= 1'b1;
          o_data  <= m3;
        end
      end
    end
  end

  // Line buffer needs no reset: every slot is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (accept && !bypass_q && col[0] && !row[0]) lbuf[h] <= m2;
  end

endmodule

// File: tb/tb_stream_maxpool2x2.sv
// Bench for stream_maxpool2x2: config table, hand-written corner sequences and
// random frames checked cycle by cycle against a 2-D frame model.
module tb_stream_maxpool2x2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_bypass, i_valid;
  logic [6:0]  i_cols, i_rows;
  logic [20:0] i_data;
  logic        o_valid, o_busy, o_done, o_err;
  logic [20:0] o_data;

  stream_maxpool2x2 dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cols(i_cols), .i_rows(i_rows),
    .i_bypass(i_bypass), .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid),
    .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cols; int rows; bit byp; bit exp_err; int pmode; int gmode;
  } cfg_vec_t;

  int          nvec = 0, nerr = 0;
  logic [20:0] pix [0:15][0:63];
  logic [20:0] got_q [$];
  logic [20:0] cust [$];
  logic [20:0] last_out = '0;
  cfg_vec_t    tbl [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] mx(input logic [20:0] a, input logic [20:0] b);
    return (a > b) ? a : b;
  endfunction

  // One pixel with optional leading idle cycles; checks the cycle after acceptance.
  task automatic feed(input logic [20:0] d, input bit ev, input logic [20:0] ed,
                      input bit edone, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      i_valid = 1'b0;
      i_data  = 21'($urandom);
      @(negedge clk);
      check("gap_valid", o_valid, 0);
      check("gap_hold", o_data, last_out);
      check("gap_done", o_done, 0);
    end
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
    check("o_valid", o_valid, ev);
    if (ev) begin
      check("o_data", o_data, ed);
      got_q.push_back(o_data);
      last_out = o_data;
    end else begin
      check("o_data_hold", o_data, last_out);
    end
    check("o_done", o_done, edone);
  endtask

  // pmode: 0 raster idx, 1 random, 2 (c==37)?1000:c, 3 raster idx+1, 4 cust list
  // gmode: 0 continuous, 1 random gaps, 2 one gap per pixel
  task automatic run_frame(input int cols, input int rows, input bit byp, input bit exp_err,
                           input int pmode, input int gmode);
    bit          ev, last;
    logic [20:0] ed;
    got_q.delete();
    i_start = 1'b1; i_cols = 7'(cols); i_rows = 7'(rows); i_bypass = byp;
    @(negedge clk);
    i_start = 1'b0;
    check("o_err", o_err, exp_err);
    check("o_busy", o_busy, !exp_err);
    if (exp_err) begin
      @(negedge clk);
      check("o_err_pulse", o_err, 0);
      check("o_busy_idle", o_busy, 0);
      return;
    end
    // latched config must be used; scramble the live inputs
    i_cols = 7'($urandom); i_rows = 7'($urandom); i_bypass = 1'($urandom);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        case (pmode)
          0:       pix[r][c] = 21'(r * cols + c);
          1:       pix[r][c] = 21'($urandom);
          2:       pix[r][c] = (c == 37) ? 21'd1000 : 21'(c);
          3:       pix[r][c] = 21'(r * cols + c + 1);
          default: pix[r][c] = cust[r * cols + c];
        endcase
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        last = (r == rows - 1) && (c == cols - 1);
        if (byp) begin
          ev = 1'b1;
          ed = pix[r][c];
        end else begin
          ev = (r % 2 == 1) && (c % 2 == 1);
          ed = ev ? mx(mx(pix[r-1][c-1], pix[r-1][c]), mx(pix[r][c-1], pix[r][c])) : '0;
        end
        feed(pix[r][c], ev, ed, last,
             (gmode == 0) ? 0 : (gmode == 1) ? int'($urandom_range(0, 3)) : 1);
      end
    @(negedge clk);
    check("done_pulse", o_done, 0);
    check("busy_after", o_busy, 0);
    check("valid_after", o_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_cols = '0; i_rows = '0; i_bypass = 1'b0;
    i_valid = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", o_valid, 0); check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);   check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // i_valid in IDLE must be ignored
    i_valid = 1'b1; i_data = 21'd77;
    @(negedge clk);
    i_valid = 1'b0;
    check("idle_valid", o_valid, 0);
    check("idle_busy", o_busy, 0);

    // 4x4 raster, continuous then toggling valid
    run_frame(4, 4, 0, 0, 0, 0);
    check("r4_count", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      check("r4_o0", got_q[0], 5);  check("r4_o1", got_q[1], 7);
      check("r4_o2", got_q[2], 13); check("r4_o3", got_q[3], 15);
    end
    run_frame(4, 4, 0, 0, 0, 2);
    check("r4t_count", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      check("r4t_o0", got_q[0], 5);  check("r4t_o3", got_q[3], 15);
    end

    // bypass 2x2
    cust = '{21'd9, 21'd3, 21'd8, 21'd1};
    run_frame(2, 2, 1, 0, 4, 0);
    check("byp_count", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      check("byp_o0", got_q[0], 9); check("byp_o1", got_q[1], 3);
      check("byp_o2", got_q[2], 8); check("byp_o3", got_q[3], 1);
    end

    // full-width line buffer
    run_frame(64, 2, 0, 0, 2, 0);
    check("w64_count", 32'(got_q.size()), 32);
    if (got_q.size() == 32) begin
      check("w64_h18", got_q[18], 1000);
      check("w64_h0", got_q[0], 1);
      check("w64_h31", got_q[31], 63);
    end

    // config table: illegal configs and a spread of legal ones
    tbl.push_back('{5, 4, 0, 1, 0, 0});
    tbl.push_back('{0, 3, 0, 1, 0, 0});
    tbl.push_back('{4, 3, 0, 1, 0, 0});
    tbl.push_back('{4, 0, 0, 1, 0, 0});
    tbl.push_back('{66, 2, 0, 1, 0, 0});
    tbl.push_back('{2, 2, 0, 0, 1, 0});
    tbl.push_back('{4, 4, 0, 0, 1, 1});
    tbl.push_back('{8, 4, 0, 0, 1, 2});
    tbl.push_back('{6, 6, 1, 0, 1, 1});
    tbl.push_back('{64, 4, 0, 0, 1, 1});
    tbl.push_back('{2, 16, 0, 0, 1, 0});
    foreach (tbl[i])
      run_frame(tbl[i].cols, tbl[i].rows, tbl[i].byp, tbl[i].exp_err, tbl[i].pmode, tbl[i].gmode);

    // random legal frames
    for (int k = 0; k < 6; k++)
      run_frame(2 * int'($urandom_range(1, 32)), 2 * int'($urandom_range(1, 8)),
                1'($urandom), 0, 1, 1);

    // reset mid-frame, then a clean 2x2 frame
    i_start = 1'b1; i_cols = 7'd4; i_rows = 7'd4; i_bypass = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) feed(21'(k), k == 5, 21'd5, 0, 0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", o_valid, 0); check("abort_data", o_data, 0);
    check("abort_busy", o_busy, 0);   check("abort_done", o_done, 0);
    check("abort_err", o_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_out = '0;
    @(negedge clk);
    check("abort_idle", o_busy, 0);
    run_frame(2, 2, 0, 0, 3, 0);
    check("post_count", 32'(got_q.size()), 1);
    if (got_q.size() == 1) check("post_o0", got_q[0], 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
